// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: the pipeline request/response signals and
// the RAM-side port. The unit uses the slave modport; the surrounding system
// (pipeline plus RAM) uses the master modport.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  // Pipeline side
  logic              MemRead;
  logic              MemWrite;
  logic [1:0]        mem_size;
  logic              mem_sign;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic              mem_stall;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              mem_exc;

  // RAM side
  logic              ram_re;
  logic              ram_we;
  logic [3:0]        ram_wstrb;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data;
  logic [31:0]       ram_rdata;
  logic              ram_ack;

  modport slave (
    input  MemRead, MemWrite, mem_size, mem_sign, mem_address, mem_wdata,
    input  ram_rdata, ram_ack,
    output mem_stall, mem_rdata, mem_rvalid, mem_exc,
    output ram_re, ram_we, ram_wstrb, ram_address, ram_data
  );

  modport master (
    output MemRead, MemWrite, mem_size, mem_sign, mem_address, mem_wdata,
    output ram_rdata, ram_ack,
    input  mem_stall, mem_rdata, mem_rvalid, mem_exc,
    input  ram_re, ram_we, ram_wstrb, ram_address, ram_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns pipeline load/store requests into word-aligned RAM
// accesses with byte-lane strobes, extracts and extends load data, and aborts
// an access when the RAM does not acknowledge within TIMEOUT wait cycles.
// Optional feature: define MEM_MISALIGN_EXC_EN to fault misaligned halfword
// and word accesses without touching the RAM.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15   // 1..255
) (
  input logic              clk,
  input logic              resetn,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  // Counter value seen in the last permitted wait cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic              req_read_q;
  logic [1:0]        req_size_q;
  logic              req_sign_q;
  logic [1:0]        req_lane_q;
  logic              fault_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q;

  logic              req_any;
  logic              take_req;
  logic              misalign;
  logic              timeout_hit;
  logic [31:0]       lane_data;
  logic [3:0]        lane_strb;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  assign req_any     = bus.MemRead | bus.MemWrite;
  assign timeout_hit = (state_q == ST_WAIT) && !bus.ram_ack && (cnt_q == CNT_LAST);

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = ((bus.mem_size == 2'd1) && bus.mem_address[0]) ||
                    (bus.mem_size[1] && (bus.mem_address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store data placement: replicate the right-aligned data into every lane
  // and pick the strobes from the low address bits.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    lane_data = bus.mem_wdata;
    lane_strb = 4'b1111;
    case (bus.mem_size)
      2'd0: begin
        lane_data = {4{bus.mem_wdata[7:0]}};
        lane_strb = 4'b0001 << bus.mem_address[1:0];
      end
      2'd1: begin
        lane_data = {2{bus.mem_wdata[15:0]}};
        lane_strb = bus.mem_address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load data extraction from the RAM word using the registered request.
  always_comb begin
    byte_sel = bus.ram_rdata[7:0];
    half_sel = bus.ram_rdata[15:0];
    load_ext = bus.ram_rdata;
    case (req_lane_q)
      2'd1:    byte_sel = bus.ram_rdata[15:8];
      2'd2:    byte_sel = bus.ram_rdata[23:16];
      2'd3:    byte_sel = bus.ram_rdata[31:24];
      default: byte_sel = bus.ram_rdata[7:0];
    endcase
    if (req_lane_q[1]) half_sel = bus.ram_rdata[31:16];
    case (req_size_q)
      2'd0:    load_ext = {{24{req_sign_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{req_sign_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.ram_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          take_req = 1'b1;
          state_d  = misalign ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.ram_ack || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter, fault flag and load result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: these are plain datapath registers, not a memory array, so they
      // are all reset; the outputs they drive must read zero during reset.
      cnt_q      <= '0;
      req_read_q <= 1'b0;
      req_size_q <= '0;
      req_sign_q <= 1'b0;
      req_lane_q <= '0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
    end else if (take_req) begin
      req_read_q <= bus.MemRead;   // read wins when both are requested
      req_size_q <= bus.mem_size;
      req_sign_q <= bus.mem_sign;
      req_lane_q <= bus.mem_address[1:0];
      addr_q     <= {bus.mem_address[ADDR_W-1:2], 2'b00};
      wdata_q    <= lane_data;
      wstrb_q    <= bus.MemRead ? 4'b0000 : lane_strb;
      fault_q    <= misalign;
      cnt_q      <= '0;
    end else if (state_q == ST_WAIT) begin
      if (bus.ram_ack) begin
        if (req_read_q) rdata_q <= load_ext;
      end else begin
        cnt_q <= cnt_q + 8'd1;
        if (timeout_hit) fault_q <= 1'b1;
      end
    end
  end

  assign bus.mem_stall   = ((state_q == ST_IDLE) && req_any) || (state_q == ST_WAIT);
  assign bus.ram_re      = (state_q == ST_WAIT) && req_read_q;
  assign bus.ram_we      = (state_q == ST_WAIT) && !req_read_q;
  assign bus.ram_wstrb   = wstrb_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data    = wdata_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.mem_rvalid  = (state_q == ST_DONE) && req_read_q && !fault_q;
  assign bus.mem_exc     = (state_q == ST_DONE) && fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed known-answer cases plus randomized
// loads/stores against a RAM model with programmable ack delay. Expected RAM
// accesses and pipeline responses are queued at issue time and popped by
// independent monitor processes.
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 255;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    bit          exc;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ram_exp_t;

  resp_t    resp_q[$];
  ram_exp_t ram_q[$];

  int          tests = 0;
  int          failed = 0;
  int          ram_delay = NEVER;
  logic [31:0] ram_word = 32'h0;
  bit          ram_manual = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_model(logic [31:0] word, logic [31:0] addr,
                                             logic [1:0] size, bit sign);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (word >> (8 * addr[1:0])) & 32'hFF;
      if (sign && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (word >> (16 * addr[1])) & 32'hFFFF;
      if (sign && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_data(logic [31:0] wdata, logic [1:0] size);
    if (size == 2'd0) return (wdata & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [3:0] store_strb(logic [31:0] addr, logic [1:0] size);
    if (size == 2'd0) return 4'(1 << addr[1:0]);
    if (size == 2'd1) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit misaligned(logic [31:0] addr, logic [1:0] size);
`ifdef MEM_MISALIGN_EXC_EN
    return (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- RAM model and RAM-side monitor ----------------
  initial begin
    int       cnt;
    ram_exp_t e;
    cnt = 0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (ram_manual) begin
        cnt = 0;
        continue;
      end
      bus.ram_rdata = ram_word;
      if (bus.ram_re || bus.ram_we) begin
        if (cnt == 0) begin
          check("ram_re_we_exclusive", bus.ram_re & bus.ram_we, 0);
          if (ram_q.size() == 0) begin
            check("ram_unexpected_access", 1, 0);
          end else begin
            e = ram_q.pop_front();
            check("ram_we", bus.ram_we, e.we);
            check("ram_re", bus.ram_re, !e.we);
            check("ram_address", bus.ram_address, e.addr);
            check("ram_wstrb", bus.ram_wstrb, e.strb);
            if (e.we) check("ram_data", bus.ram_data, e.data);
          end
        end
        bus.ram_ack = (cnt == ram_delay);
        cnt++;
      end else begin
        bus.ram_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // ---------------- pipeline-side response monitor ----------------
  initial begin
    logic [31:0] hold;
    resp_t       r;
    hold = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold = 32'h0;
        continue;
      end
      if (bus.mem_rvalid || bus.mem_exc) begin
        if (resp_q.size() == 0) begin
          check("unexpected_response", {bus.mem_rvalid, bus.mem_exc}, 0);
        end else begin
          r = resp_q.pop_front();
          check("mem_exc", bus.mem_exc, r.exc);
          check("mem_rvalid", bus.mem_rvalid, !r.exc);
          if (!r.exc) begin
            check("mem_rdata", bus.mem_rdata, r.data);
            hold = r.data;
          end else begin
            check("mem_rdata_hold_on_exc", bus.mem_rdata, hold);
          end
        end
      end else begin
        check("mem_rdata_hold", bus.mem_rdata, hold);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input bit rd, input bit wr, input logic [1:0] size, input bit sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] word);
    bit       mis, fault;
    int       exp_lat, k;
    ram_exp_t e;
    resp_t    r;
    mis   = misaligned(addr, size);
    fault = mis || (delay >= TIMEOUT);
    if (mis)                 exp_lat = 1;
    else if (delay < TIMEOUT) exp_lat = delay + 2;
    else                     exp_lat = TIMEOUT + 1;

    if (!mis) begin
      e.we   = !rd;
      e.addr = addr & 32'hFFFF_FFFC;
      e.data = store_data(wdata, size);
      e.strb = rd ? 4'b0000 : store_strb(addr, size);
      ram_q.push_back(e);
    end
    if (fault) begin
      r.exc  = 1'b1;
      r.data = 32'h0;
      resp_q.push_back(r);
    end else if (rd) begin
      r.exc  = 1'b0;
      r.data = load_model(word, addr, size, sign);
      resp_q.push_back(r);
    end

    @(negedge clk);
    ram_delay       = delay;
    ram_word        = word;
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.mem_size    = size;
    bus.mem_sign    = sign;
    bus.mem_address = addr;
    bus.mem_wdata   = wdata;
    #1 check("stall_request_cycle", bus.mem_stall, 1);
    for (k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (!bus.mem_stall) break;
    end
    check("latency", k, exp_lat);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.mem_wdata = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},   bus.mem_stall, 0);
    check({tag, "_rvalid"},  bus.mem_rvalid, 0);
    check({tag, "_exc"},     bus.mem_exc, 0);
    check({tag, "_ram_re"},  bus.ram_re, 0);
    check({tag, "_ram_we"},  bus.ram_we, 0);
    check({tag, "_wstrb"},   bus.ram_wstrb, 0);
    check({tag, "_address"}, bus.ram_address, 0);
    check({tag, "_data"},    bus.ram_data, 0);
    check({tag, "_rdata"},   bus.mem_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_exp_t e;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.mem_size    = 2'd0;
    bus.mem_sign    = 1'b0;
    bus.mem_address = 32'h0;
    bus.mem_wdata   = 32'h0;
    resetn          = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 resetn = 1'b1;
    @(negedge clk);

    // Known-answer cases
    do_txn(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    check("ld_word_const", bus.mem_rdata, 32'hDEAD_BEEF);
    do_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h8011_2233);
    check("ld_sbyte_const", bus.mem_rdata, 32'hFFFF_FF80);
    do_txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 32'h8011_2233);
    check("ld_ubyte_const", bus.mem_rdata, 32'h0000_0080);
    do_txn(0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 2, 32'h0);
    do_txn(1, 0, 2'd2, 0, 32'h100, 32'h0, NEVER, 32'h1111_2222);
    check("timeout_rdata_unchanged", bus.mem_rdata, 32'h0000_0080);
    do_txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 32'h1234_5678);
    do_txn(1, 1, 2'd1, 1, 32'h306, 32'hFFFF, 0, 32'h8001_7FFF);
    do_txn(0, 1, 2'd0, 0, 32'h041, 32'h5A, TIMEOUT - 1, 32'h0);
    do_txn(0, 1, 2'd3, 0, 32'h044, 32'hCAFE_F00D, NEVER, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      bit rd, wr;
      int dly;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 4));
      do_txn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom & 32'h0000_FFFF, $urandom, dly, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of a wait, then a late ack after release
    ram_delay = NEVER;
    e.we = 1'b0; e.addr = 32'h400; e.data = 32'h0; e.strb = 4'b0000;
    ram_q.push_back(e);
    @(negedge clk);
    bus.MemRead     = 1'b1;
    bus.mem_size    = 2'd2;
    bus.mem_address = 32'h400;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    bus.MemRead = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    ram_manual = 1'b1;
    @(negedge clk);
    bus.ram_ack = 1'b1;
    @(negedge clk);
    bus.ram_ack = 1'b0;
    ram_manual  = 1'b0;
    repeat (3) begin
      check("late_ack_rvalid", bus.mem_rvalid, 0);
      check("late_ack_exc", bus.mem_exc, 0);
      check("late_ack_stall", bus.mem_stall, 0);
      check("late_ack_ram_re", bus.ram_re, 0);
      @(negedge clk);
    end
    do_txn(1, 0, 2'd1, 1, 32'h502, 32'h0, 1, 32'h9ABC_0000);
    check("post_reset_load", bus.mem_rdata, 32'hFFFF_9ABC);

    repeat (3) @(negedge clk);
    check("resp_queue_drained", resp_q.size(), 0);
    check("ram_queue_drained", ram_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32, RAM address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles for ram_ack before abort; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 MemRead / MemWrite  in  1 each  load / store request from pipeline, held stable while mem_stall=1.
REQ-006 mem_size  in  2  access size: 0 byte, 1 halfword, 2 word, 3 reserved (treated as word).
REQ-007 mem_sign  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 mem_address  in  ADDR_W  byte address; mem_wdata  in  32  store data, right-aligned.
REQ-009 mem_stall  out  1  pipeline hold; mem_rdata  out  32  extended load result; mem_rvalid  out  1  load result valid; mem_exc  out  1  access fault pulse.
REQ-010 ram_re / ram_we  out  1 each  RAM read / write enable; ram_wstrb  out  4  byte-lane write strobes.
REQ-011 ram_address  out  ADDR_W  word-aligned address (bits [1:0] = 0); ram_data  out  32  lane-positioned write data.
REQ-012 ram_rdata  in  32  RAM read word; ram_ack  in  1  RAM completion, one cycle, valid only while ram_re or ram_we is high.

Function
REQ-013 FSM states IDLE, WAIT, DONE; encoding free.
REQ-014 IDLE: on MemRead or MemWrite, register request (address, size, sign, lane data, strobes), clear wait counter, go WAIT; mem_stall=1 combinationally that cycle.
REQ-015 MemRead and MemWrite both high: read performed, write ignored, no exception.
REQ-016 WAIT: ram_re or ram_we held high with registered address/data/strobes; mem_stall=1.
REQ-017 WAIT with ram_ack=1: drop ram_re/ram_we next cycle, capture extracted load data, go DONE.
REQ-018 WAIT without ack: counter +1; counter reaching TIMEOUT with no ack -> go DONE with mem_exc=1, mem_rvalid=0, mem_rdata unchanged.
REQ-019 DONE: mem_stall=0 for exactly one cycle; mem_rvalid=1 for that cycle if the access was a read without fault; mem_exc=1 that cycle if faulted; go IDLE unconditionally.
REQ-020 Minimum latency: request cycle 0, WAIT cycle 1 with ack, DONE cycle 2.
REQ-021 Store byte: ram_data = wdata[7:0] replicated in all 4 lanes, ram_wstrb = 1 << addr[1:0].
REQ-022 Store halfword: ram_data = wdata[15:0] replicated twice, ram_wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-023 Store word: ram_data = wdata, ram_wstrb = 1111; reads drive ram_wstrb = 0000.
REQ-024 Load: lane selected by addr[1:0] (byte) or addr[1] (half), extended to 32 bits per mem_sign; word loads ignore mem_sign.
REQ-025 mem_rdata holds its value between loads.

Reset
REQ-026 resetn low: immediately FSM=IDLE, counter=0, mem_stall=0, mem_rvalid=0, mem_exc=0, ram_re=0, ram_we=0, ram_wstrb=0, ram_address=0, ram_data=0, mem_rdata=0.
REQ-027 Reset during WAIT abandons the access; a late ram_ack after reset release is ignored in IDLE.

Configuration
REQ-028 Macro MEM_MISALIGN_EXC_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE directly, no RAM enable asserted, mem_exc=1 in DONE.
REQ-029 MEM_MISALIGN_EXC_EN undefined: misalignment not detected; low address bits below access size ignored (word uses lane 0, half uses addr[1]).

Verification
REQ-030 Load word addr 0x100, ram_rdata 0xDEADBEEF, ack in first WAIT cycle -> mem_rvalid=1 with mem_rdata 0xDEADBEEF at cycle 2, stall high cycles 0-1.
REQ-031 Signed byte load addr 0x103, ram_rdata 0x80112233 -> mem_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Halfword store addr 0x202, wdata 0x0000ABCD -> ram_address 0x200, ram_data 0xABCDABCD, ram_wstrb 1100, ram_we until ack.
REQ-033 Read, ram_ack never asserted, TIMEOUT=15 -> mem_exc pulse after 15 WAIT cycles, mem_rvalid=0, FSM returns IDLE.
REQ-034 With MEM_MISALIGN_EXC_EN, word load addr 0x101 -> ram_re never high, mem_exc=1 at cycle 1; without macro -> ram_address 0x100, normal completion.
REQ-035 resetn low during WAIT, ack one cycle after release -> all outputs zero, no mem_rvalid, next request served normally.
